// File: rtl/group_cla_adder.sv
// ---------------------------------------------------------------------------
// group_cla_adder
//
// Multi-cycle adder/subtractor. A WIDTH-bit operation is split into
// N = WIDTH/GROUP_W groups. One group is evaluated per clock with a small
// carry-lookahead network, and the group carry-out is registered and fed to
// the next group. Wide operands therefore never build a long combinational
// carry chain.
//
// Parameters
//   WIDTH    operand/result width, positive multiple of GROUP_W
//   GROUP_W  bits evaluated per clock
//
// Ports
//   clk_i     clock, all state changes on the rising edge
//   rst_i     synchronous active-high reset
//   start_i   request, accepted when busy_o is low
//   sub_i     0: A+B+C0, 1: A+~B+1 (C0 ignored); sampled at accept
//   A_i, B_i  operands, sampled at accept
//   C0_i      carry-in for add, sampled at accept
//   busy_o    operation in progress
//   done_o    one-cycle pulse, results valid
//   F_o       registered result
//   C_out_o   carry out of the MSB (for subtract: 1 = no borrow)
//   OF_o      signed overflow (carry into MSB xor carry out of MSB)
//   ZF_o      result is zero
// ---------------------------------------------------------------------------
module group_cla_adder #(
  parameter int WIDTH   = 32,
  parameter int GROUP_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             C0_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] F_o,
  output logic             C_out_o,
  output logic             OF_o,
  output logic             ZF_o
);

  localparam int N  = WIDTH / GROUP_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [WIDTH-1:0]   F_q, F_d;
  logic               carry_q, carry_d;
  logic               cOut_q, cOut_d;
  logic               of_q, of_d;
  logic               zf_q, zf_d;

  int                 grpBase;
  logic [GROUP_W-1:0] grpA, grpB, grpG, grpP, grpSum;
  logic [GROUP_W:0]   grpC;
  logic               lookTerm, lookProd;
  logic               accept;

  // Group slice selection and in-group lookahead. Each carry is expanded as
  // G[i] | P[i]G[i-1] | ... | P[i..0]c0 so the group carries are flat
  // sum-of-products terms of the registered carry, not a ripple.
  always_comb begin
    grpBase  = int'(cnt_q) * GROUP_W;
    grpA     = a_q[grpBase +: GROUP_W];
    grpB     = b_q[grpBase +: GROUP_W];
    grpG     = grpA & grpB;
    grpP     = grpA | grpB;
    grpC     = '0;
    grpC[0]  = carry_q;
    lookTerm = 1'b0;
    lookProd = 1'b0;
    for (int i = 0; i < GROUP_W; i++) begin
      lookTerm = grpG[i];
      lookProd = grpP[i];
      for (int j = i - 1; j >= 0; j--) begin
        lookTerm = lookTerm | (lookProd & grpG[j]);
        lookProd = lookProd & grpP[j];
      end
      grpC[i+1] = lookTerm | (lookProd & carry_q);
    end
    grpSum = grpA ^ grpB ^ grpC[GROUP_W-1:0];
  end

  // Next-state and datapath update. A new request is accepted from IDLE or
  // from the single DONE cycle, which gives back-to-back operation when
  // start is held. Visible outputs are only loaded on the last group.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    F_d     = F_q;
    cOut_d  = cOut_q;
    of_d    = of_q;
    zf_d    = zf_q;
    accept  = start_i && (state_q != CALC);

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      CALC: begin
        sum_d[grpBase +: GROUP_W] = grpSum;
        carry_d = grpC[GROUP_W];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          F_d     = sum_d;
          cOut_d  = grpC[GROUP_W];
          of_d    = grpC[GROUP_W] ^ grpC[GROUP_W-1];
          zf_d    = (sum_d == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Subtract is A + ~B + 1: invert B at load and force the carry-in.
    if (accept) begin
      state_d = CALC;
      cnt_d   = '0;
      a_d     = A_i;
      b_d     = sub_i ? ~B_i : B_i;
      carry_d = sub_i | C0_i;
    end
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      F_q     <= '0;
      cOut_q  <= 1'b0;
      of_q    <= 1'b0;
      zf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      F_q     <= F_d;
      cOut_q  <= cOut_d;
      of_q    <= of_d;
      zf_q    <= zf_d;
    end
  end

  assign busy_o  = (state_q == CALC);
  assign done_o  = (state_q == DONE);
  assign F_o     = F_q;
  assign C_out_o = cOut_q;
  assign OF_o    = of_q;
  assign ZF_o    = zf_q;

endmodule
